// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-requester front end for a single-port RAM,
// with a sequencer that fills every location with CLR_VALUE.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    typedef enum logic {SERVE, CLEAR} state_e;

    localparam logic [ADDR_WIDTH:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic                ptr_q, ptr_d;
    logic                busy_q, clr_done_q, rvalid0_q, rvalid1_q;
    logic                serve, arb;

    always_comb begin
        serve    = state_q == SERVE;
        arb      = serve && !clr_start;
        // ptr_q names the requester that wins a tie
        gnt0     = arb && req0 && (!req1 || !ptr_q);
        gnt1     = arb && req1 && (!req0 || ptr_q);
        ram_we   = serve ? (gnt0 ? we0 : gnt1 ? we1 : 1'b0) : 1'b1;
        ram_addr = serve ? (gnt0 ? addr0 : gnt1 ? addr1 : '0) : cnt_q[ADDR_WIDTH-1:0];
        ram_d    = serve ? (gnt0 ? wdata0 : gnt1 ? wdata1 : '0) : CLR_VALUE;
        state_d  = serve ? (clr_start ? CLEAR : SERVE) : (cnt_q == LAST ? SERVE : CLEAR);
        cnt_d    = serve ? '0 : cnt_q + ONE;
        ptr_d    = gnt0 ? 1'b1 : gnt1 ? 1'b0 : ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SERVE;
            cnt_q      <= '0;
            ptr_q      <= 1'b0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            busy_q     <= state_d == CLEAR;
            clr_done_q <= !serve && state_d == SERVE;
            rvalid0_q  <= gnt0 && !we0;
            rvalid1_q  <= gnt1 && !we1;
        end
    end

    assign busy     = busy_q;
    assign clr_done = clr_done_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = ram_q;
    assign rdata1   = ram_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for ram_port_arbiter with a behavioural
// single-port RAM (registered read, old data on read-during-write).
module tb_ram_port_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam logic [DW-1:0] CV = 8'h3C;

    logic clk = 1'b0, reset = 1'b0, clr_start = 1'b0;
    logic busy, clr_done, gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0, ram_addr;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, rdata0, rdata1, ram_d, ram_q;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] sb_mem [16];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    int passed = 0, total = 0;

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLR_VALUE(CV)) dut (
        .clk(clk), .reset(reset), .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 16; i++) begin
        mem[i]    = 8'h80 + 8'(i);
        sb_mem[i] = 8'h80 + 8'(i);
    end

    always @(posedge clk) begin
        ram_q <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_d;
    end

    // Samples 1 time unit before each rising edge: returns first, then acceptances.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        #4;
        if (!reset && rvalid0) begin
            total++;
            if (q0.size() == 0) $display("FAIL rvalid0_spurious got rvalid0=1 expected 0");
            else begin
                e = q0.pop_front();
                if (rdata0 !== e) $display("FAIL rdata0 got %h expected %h", rdata0, e);
                else passed++;
            end
        end
        if (!reset && rvalid1) begin
            total++;
            if (q1.size() == 0) $display("FAIL rvalid1_spurious got rvalid1=1 expected 0");
            else begin
                e = q1.pop_front();
                if (rdata1 !== e) $display("FAIL rdata1 got %h expected %h", rdata1, e);
                else passed++;
            end
        end
        if (!reset && req0 && gnt0) begin
            if (we0) sb_mem[addr0] = wdata0;
            else q0.push_back(sb_mem[addr0]);
        end
        if (!reset && req1 && gnt1) begin
            if (we1) sb_mem[addr1] = wdata1;
            else q1.push_back(sb_mem[addr1]);
        end
    end

    task automatic drv0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic drv1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drv0(0, 0, 0, 0); drv1(0, 0, 0, 0); clr_start = 1'b0;
        reset = 1'b1;
        q0.delete(); q1.delete();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else passed++;
        total++; if (clr_done !== 1'b0) $display("FAIL reset_clr_done got %b expected 0", clr_done); else passed++;
        total++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL reset_rvalid got %b expected 00", {rvalid0, rvalid1}); else passed++;
        total++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we got %b expected 0", ram_we); else passed++;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        drv0(1, 1, 5, 8'hA5);
        #1;
        total++; if (gnt0 !== 1'b1) $display("FAIL wr_gnt0 got %b expected 1", gnt0); else passed++;
        total++; if ({ram_we, ram_addr, ram_d} !== {1'b1, 4'd5, 8'hA5}) $display("FAIL wr_ram got %b/%h/%h expected 1/5/a5", ram_we, ram_addr, ram_d); else passed++;
        @(negedge clk);
        drv0(1, 0, 5, 0);
        #1;
        total++; if (gnt0 !== 1'b1) $display("FAIL rd_gnt0 got %b expected 1", gnt0); else passed++;
        total++; if (rvalid0 !== 1'b0) $display("FAIL wr_no_rvalid got %b expected 0", rvalid0); else passed++;
        @(negedge clk);
        drv0(0, 0, 0, 0);
        #1;
        total++; if (rvalid0 !== 1'b1) $display("FAIL rd_rvalid0 got %b expected 1", rvalid0); else passed++;
        @(negedge clk);
        #1;
        total++; if (rvalid0 !== 1'b0) $display("FAIL rd_rvalid0_drop got %b expected 0", rvalid0); else passed++;
        @(negedge clk);
    endtask

    task automatic test_contention();
        drv0(1, 0, 1, 0); drv1(1, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL rr_gnt%0d got %b", i, {gnt0, gnt1});
            else passed++;
            if (i > 0) begin
                total++;
                if ({rvalid0, rvalid1} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) $display("FAIL rr_rvalid%0d got %b", i, {rvalid0, rvalid1});
                else passed++;
            end
            @(negedge clk);
        end
        drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);
        #1;
        total++; if ({rvalid0, rvalid1} !== 2'b01) $display("FAIL rr_rvalid_last got %b expected 01", {rvalid0, rvalid1}); else passed++;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_write_then_read();
        drv0(1, 1, 3, 8'h11); drv1(1, 0, 3, 0);
        #1;
        total++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL wfirst_gnt got %b expected 10", {gnt0, gnt1}); else passed++;
        @(negedge clk);
        drv0(0, 0, 0, 0);
        #1;
        total++; if (gnt1 !== 1'b1) $display("FAIL wfirst_gnt1 got %b expected 1", gnt1); else passed++;
        @(negedge clk);
        drv1(0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_clear(input logic hold1);
        int bad_seq = 0, bad_gnt = 0;
        drv0(1, 1, 9, 8'h77);
        if (hold1) drv1(1, 0, 15, 0);
        clr_start = 1'b1;
        #1;
        total++; if ({gnt0, gnt1, ram_we} !== 3'b000) $display("FAIL clr_start_prio got %b expected 000", {gnt0, gnt1, ram_we}); else passed++;
        @(negedge clk);
        clr_start = 1'b0;
        drv0(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            #1;
            if (i == 3) clr_start = 1'b1;
            if ({busy, ram_we, ram_addr, ram_d, clr_done} !== {1'b1, 1'b1, 4'(i), CV, 1'b0}) bad_seq++;
            if (gnt0 || gnt1) bad_gnt++;
            @(negedge clk);
            clr_start = 1'b0;
        end
        for (int i = 0; i < 16; i++) sb_mem[i] = CV;
        total++; if (bad_seq != 0) $display("FAIL clr_seq got %0d bad cycles expected 0", bad_seq); else passed++;
        total++; if (bad_gnt != 0) $display("FAIL clr_gnt got %0d granted cycles expected 0", bad_gnt); else passed++;
        #1;
        total++; if ({busy, clr_done} !== 2'b01) $display("FAIL clr_done got busy/done %b expected 01", {busy, clr_done}); else passed++;
        if (hold1) begin
            total++; if (gnt1 !== 1'b1) $display("FAIL clr_exit_gnt1 got %b expected 1", gnt1); else passed++;
        end
        @(negedge clk);
        drv1(0, 0, 0, 0);
        #1;
        total++; if ({busy, clr_done} !== 2'b00) $display("FAIL clr_after got busy/done %b expected 00", {busy, clr_done}); else passed++;
        @(negedge clk);
        drv0(1, 0, 0, 0);
        @(negedge clk);
        drv0(1, 0, 15, 0);
        @(negedge clk);
        drv0(0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_abort();
        int n = 0, dones = 0;
        logic [AW-1:0] wa [4] = '{4'd0, 4'd6, 4'd8, 4'd15};
        for (int i = 0; i < 4; i++) begin
            drv0(1, 1, wa[i], 8'h50 + 8'(i));
            @(negedge clk);
        end
        drv0(0, 0, 0, 0);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        #1;
        while (!(busy && ram_addr == 4'd7) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++; if (n >= 20) $display("FAIL abort_reach7 got timeout expected ram_addr=7"); else passed++;
        reset = 1'b1;
        #1;
        total++; if ({busy, ram_we, clr_done} !== 3'b000) $display("FAIL abort_now got %b expected 000", {busy, ram_we, clr_done}); else passed++;
        for (int i = 0; i < 7; i++) sb_mem[i] = CV;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (clr_done || busy) dones++;
            @(negedge clk);
        end
        total++; if (dones != 0) $display("FAIL abort_no_done got %0d cycles expected 0", dones); else passed++;
        for (int i = 0; i < 4; i++) begin
            drv0(1, 0, wa[i], 0);
            @(negedge clk);
        end
        drv0(0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_reset();
        test_contention();
        test_reset();
        test_write_then_read();
        test_clear(1'b0);
        test_clear(1'b1);
        test_abort();
        total++;
        if (q0.size() != 0 || q1.size() != 0) $display("FAIL sb_drain got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
